// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and a shared RAM port.
// Define STORE_BUF_FWD_EN to enable store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic              full;
  logic              push;
  logic              pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full;

`ifdef STORE_BUF_FWD_EN
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PW-1:0]     idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count && mem_addr[idx] == ld_addr) begin
        hit      = 1'b1;
        hit_data = mem_data[idx];
      end
    end
  end
`endif

  always_comb begin
    ram_address  = '0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    ram_data_in  = '0;
    ld_data      = '0;
    ld_stall     = 1'b0;
    pop          = 1'b0;
`ifdef STORE_BUF_FWD_EN
    if (full) begin
      pop      = 1'b1;
      ld_stall = ld_req && !hit;
      if (ld_req && hit)
        ld_data = hit_data;
    end else if (ld_req && !hit) begin
      ram_read_en = 1'b1;
      ram_address = ld_addr;
      ld_data     = ram_out;
    end else if (!empty) begin
      pop = 1'b1;
      if (ld_req)
        ld_data = hit_data;
    end
`else
    if (!empty) begin
      pop      = 1'b1;
      ld_stall = ld_req;
    end else if (ld_req) begin
      ram_read_en = 1'b1;
      ram_address = ld_addr;
      ld_data     = ram_out;
    end
`endif
    if (pop) begin
      ram_write_en = 1'b1;
      ram_address  = mem_addr[head];
      ram_data_in  = mem_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= st_addr;
      mem_data[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based buffer/memory model.
// Follows STORE_BUF_FWD_EN the same way the design does.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [63:0] st_addr = '0;
  logic [63:0] st_data = '0;
  logic        ld_req = 1'b0;
  logic [63:0] ld_addr = '0;
  logic [63:0] ld_data;
  logic        ld_stall;
  logic [63:0] ram_address;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [63:0] ram_data_in;
  logic [63:0] ram_out;
  logic        empty;

  logic [63:0] tb_mem [16];
  logic [63:0] ref_mem [16];
  ent_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .ram_address(ram_address), .ram_read_en(ram_read_en),
    .ram_write_en(ram_write_en), .ram_data_in(ram_data_in),
    .ram_out(ram_out), .empty(empty)
  );

  assign ram_out = tb_mem[ram_address[3:0]];

  always @(posedge clk)
    if (ram_write_en)
      tb_mem[ram_address[3:0]] <= ram_data_in;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    st_valid = 1'b0;
    ld_req   = 1'b0;
    reset_n  = 1'b0;
    q.delete();
    #1;
    check("rst_empty", empty, 1);
    check("rst_st_ready", st_ready, 1);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_wr_en", ram_write_en, 0);
    check("rst_rd_en", ram_read_en, 0);
    check("rst_addr", ram_address, 0);
    check("rst_wdata", ram_data_in, 0);
    check("rst_ld_data", ld_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cycle(input logic sv, input logic [63:0] sa,
                       input logic [63:0] sd, input logic lr,
                       input logic [63:0] la);
    int          n;
    bit          full;
    bit          hit;
    bit          e_stall;
    bit          e_drain;
    bit          e_read;
    logic [63:0] val;
    @(negedge clk);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_req   = lr;
    ld_addr  = la;
    #1;
    n    = q.size();
    full = (n == DEPTH);
    hit  = 1'b0;
    val  = ref_mem[la[3:0]];
    foreach (q[i])
      if (q[i].a == la) begin
        hit = 1'b1;
        val = q[i].d;
      end
`ifdef STORE_BUF_FWD_EN
    e_stall = lr && full && !hit;
    e_drain = full || (n > 0 && !(lr && !hit));
    e_read  = lr && !hit && !full;
`else
    e_stall = lr && n > 0;
    e_drain = n > 0;
    e_read  = lr && n == 0;
`endif
    check("st_ready", st_ready, !full);
    check("empty", empty, n == 0);
    check("ld_stall", ld_stall, e_stall);
    check("ram_write_en", ram_write_en, e_drain);
    check("ram_read_en", ram_read_en, e_read);
    if (e_drain) begin
      check("drain_addr", ram_address, q[0].a);
      check("drain_data", ram_data_in, q[0].d);
    end
    if (e_read)
      check("read_addr", ram_address, la);
    if (lr && !e_stall)
      check("ld_data", ld_data, val);
    if (e_drain) begin
      ref_mem[q[0].a[3:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (sv && !full)
      q.push_back('{a: sa, d: sd});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = 64'(i * 100);
      ref_mem[i] = 64'(i * 100);
    end
    apply_reset();

    cycle(1, 5, 64'hAB, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    cycle(1, 7, 64'h11, 1, 2);
    cycle(1, 7, 64'h22, 1, 2);
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 0, 1, 7);

    cycle(1, 3, 64'h33, 1, 2);
    cycle(0, 0, 0, 1, 9);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++)
      cycle(1, 64'(10 + i), 64'(1000 + i), 1, 12);
    cycle(0, 0, 0, 1, 13);
    cycle(0, 0, 0, 1, 13);
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++)
      cycle(1, 64'(i), 64'(64'hC0 + i), 0, 0);
    cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      cycle(1, 64'(4 + i), 64'(64'hD0 + i), 1, 1);
    apply_reset();

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 9) < 6, 64'($urandom_range(0, 7)),
            {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            64'($urandom_range(0, 7)));

    for (int i = 0; i < 10; i++)
      cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      check("mem_final", tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
